// File: rtl/ebpc_znz_lane_expander_if.sv
// Stream bundle for the EBPC lane expander: block header, ZNZ mask, BPC values and output beats.
// Signal suffixes follow the expander's point of view (slave = the expander itself).
interface ebpc_znz_lane_expander_if #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned MASK_W        = 8,
    parameter int unsigned N_LANES       = 4,
    parameter int unsigned LOG_MAX_WORDS = 16
);
    logic [LOG_MAX_WORDS-1:0]  num_words_i;
    logic                      num_words_vld_i;
    logic                      num_words_rdy_o;
    logic [MASK_W-1:0]         znz_i;
    logic                      znz_vld_i;
    logic                      znz_rdy_o;
    logic [DATA_W-1:0]         bpc_i;
    logic                      bpc_vld_i;
    logic                      bpc_rdy_o;
    logic [N_LANES*DATA_W-1:0] data_o;
    logic [N_LANES-1:0]        lane_vld_o;
    logic                      last_o;
    logic                      vld_o;
    logic                      rdy_i;

    modport slave (
        input  num_words_i, num_words_vld_i, znz_i, znz_vld_i, bpc_i, bpc_vld_i, rdy_i,
        output num_words_rdy_o, znz_rdy_o, bpc_rdy_o, data_o, lane_vld_o, last_o, vld_o
    );

    modport master (
        output num_words_i, num_words_vld_i, znz_i, znz_vld_i, bpc_i, bpc_vld_i, rdy_i,
        input  num_words_rdy_o, znz_rdy_o, bpc_rdy_o, data_o, lane_vld_o, last_o, vld_o
    );
endinterface

// File: rtl/ebpc_znz_lane_expander.sv
// Merges the ZNZ mask and BPC non-zero streams into dense N_LANES-wide beats.
// Define EBPC_ZNZ_STATS_EN to add nz_cnt_o (non-zero count of the last completed block).
module ebpc_znz_lane_expander #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned MASK_W        = 8,
    parameter int unsigned N_LANES       = 4,
    parameter int unsigned LOG_MAX_WORDS = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
`ifdef EBPC_ZNZ_STATS_EN
    output logic [LOG_MAX_WORDS:0]   nz_cnt_o,
`endif
    ebpc_znz_lane_expander_if.slave  bus
);
    localparam int unsigned CNT_W  = LOG_MAX_WORDS + 1;
    localparam int unsigned LANE_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam int unsigned MB_W   = $clog2(MASK_W + 1);

    typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          elem_cnt_q, elem_cnt_d;
    logic [MASK_W-1:0]         mask_q, mask_d;
    logic [MB_W-1:0]           mask_bits_q, mask_bits_d;
    logic [LANE_W-1:0]         lane_idx_q, lane_idx_d;
    logic [N_LANES*DATA_W-1:0] data_q, data_d;
    logic [N_LANES-1:0]        lane_vld_q, lane_vld_d;
    logic                      last_q, last_d;
`ifdef EBPC_ZNZ_STATS_EN
    logic [CNT_W-1:0]          blk_nz_q, blk_nz_d;
    logic [CNT_W-1:0]          nz_cnt_q, nz_cnt_d;
`endif

    logic [CNT_W-1:0] elem_next;
    logic             place;

    // Ready depends only on registered state and reset, never on any valid.
    assign bus.num_words_rdy_o = !rst_i && (state_q == IDLE);
    assign bus.znz_rdy_o       = !rst_i && (state_q == FILL) && (mask_bits_q == '0);
    assign bus.bpc_rdy_o       = !rst_i && (state_q == FILL) && (mask_bits_q != '0) && mask_q[0];

    assign bus.data_o     = data_q;
    assign bus.lane_vld_o = lane_vld_q;
    assign bus.last_o     = last_q;
    assign bus.vld_o      = (state_q == FLUSH);
`ifdef EBPC_ZNZ_STATS_EN
    assign nz_cnt_o = nz_cnt_q;
`endif

    assign elem_next = elem_cnt_q - CNT_W'(1);
    assign place     = (state_q == FILL) && (mask_bits_q != '0) && (!mask_q[0] || bus.bpc_vld_i);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        elem_cnt_d  = elem_cnt_q;
        mask_d      = mask_q;
        mask_bits_d = mask_bits_q;
        lane_idx_d  = lane_idx_q;
        data_d      = data_q;
        lane_vld_d  = lane_vld_q;
        last_d      = last_q;
`ifdef EBPC_ZNZ_STATS_EN
        blk_nz_d    = blk_nz_q;
        nz_cnt_d    = nz_cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.num_words_vld_i && bus.num_words_rdy_o) begin
                    elem_cnt_d  = CNT_W'(bus.num_words_i) + CNT_W'(1);
                    mask_d      = '0;
                    mask_bits_d = '0;
                    lane_idx_d  = '0;
`ifdef EBPC_ZNZ_STATS_EN
                    blk_nz_d    = '0;
`endif
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (mask_bits_q == '0) begin
                    if (bus.znz_vld_i && bus.znz_rdy_o) begin
                        mask_d      = bus.znz_i;
                        mask_bits_d = MB_W'(MASK_W);
                    end
                end else if (place) begin
                    for (int k = 0; k < N_LANES; k++) begin
                        if (lane_idx_q == LANE_W'(k)) begin
                            data_d[k*DATA_W +: DATA_W] = mask_q[0] ? bus.bpc_i : '0;
                            lane_vld_d[k]              = 1'b1;
                        end
                    end
                    mask_d      = mask_q >> 1;
                    mask_bits_d = mask_bits_q - MB_W'(1);
                    elem_cnt_d  = elem_next;
                    lane_idx_d  = lane_idx_q + LANE_W'(1);
`ifdef EBPC_ZNZ_STATS_EN
                    blk_nz_d    = blk_nz_q + CNT_W'(mask_q[0]);
`endif
                    if ((lane_idx_q == LANE_W'(N_LANES - 1)) || (elem_next == '0)) begin
                        state_d = FLUSH;
                        last_d  = (elem_next == '0);
                    end
                end
            end
            FLUSH: begin
                if (bus.rdy_i) begin
                    data_d     = '0;
                    lane_vld_d = '0;
                    last_d     = 1'b0;
                    lane_idx_d = '0;
`ifdef EBPC_ZNZ_STATS_EN
                    if (last_q) nz_cnt_d = blk_nz_q;
`endif
                    // Leftover mask bits die with the block: IDLE clears them on the next header.
                    state_d = (elem_cnt_q == '0) ? IDLE : FILL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            elem_cnt_q  <= '0;
            mask_q      <= '0;
            mask_bits_q <= '0;
            lane_idx_q  <= '0;
            data_q      <= '0;
            lane_vld_q  <= '0;
            last_q      <= 1'b0;
`ifdef EBPC_ZNZ_STATS_EN
            blk_nz_q    <= '0;
            nz_cnt_q    <= '0;
`endif
        end else begin
            // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
            state_q     <= state_d;
            elem_cnt_q  <= elem_cnt_d;
            mask_q      <= mask_d;
            mask_bits_q <= mask_bits_d;
            lane_idx_q  <= lane_idx_d;
            data_q      <= data_d;
            lane_vld_q  <= lane_vld_d;
            last_q      <= last_d;
`ifdef EBPC_ZNZ_STATS_EN
            blk_nz_q    <= blk_nz_d;
            nz_cnt_q    <= nz_cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_ebpc_znz_lane_expander.sv
// Scoreboard bench for ebpc_znz_lane_expander: stream drivers feed queues, a negedge monitor
// pops expected beats and checks them, directed blocks cover masks, stalls and mid-block reset.
module tb_ebpc_znz_lane_expander;
    localparam int unsigned DW = 8;
    localparam int unsigned MW = 8;
    localparam int unsigned NL = 4;
    localparam int unsigned LW = 16;

    typedef struct packed {
        logic [NL*DW-1:0] data;
        logic [NL-1:0]    lv;
        logic             last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ebpc_znz_lane_expander_if #(.DATA_W(DW), .MASK_W(MW), .N_LANES(NL), .LOG_MAX_WORDS(LW)) bus ();
`ifdef EBPC_ZNZ_STATS_EN
    logic [LW:0] nz_cnt;
`endif

    ebpc_znz_lane_expander #(.DATA_W(DW), .MASK_W(MW), .N_LANES(NL), .LOG_MAX_WORDS(LW)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
`ifdef EBPC_ZNZ_STATS_EN
        .nz_cnt_o (nz_cnt),
`endif
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;
    int znz_xfers = 0;
    int bpc_xfers = 0;

    logic [LW-1:0] hdr_q[$];
    logic [MW-1:0] znz_q[$];
    logic [DW-1:0] bpc_q[$];
    beat_t         exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NL*DW-1:0] pack4(input logic [7:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic push_beat(input logic [NL*DW-1:0] d, input logic [NL-1:0] lv, input logic l);
        beat_t b;
        b.data = d;
        b.lv   = lv;
        b.last = l;
        exp_q.push_back(b);
    endtask

    // Header driver
    initial begin
        logic f;
        bus.num_words_vld_i = 1'b0;
        bus.num_words_i     = '0;
        forever begin
            @(negedge clk);
            f = bus.num_words_vld_i && bus.num_words_rdy_o;
            @(posedge clk);
            #1;
            if (f && hdr_q.size() > 0) void'(hdr_q.pop_front());
            bus.num_words_vld_i = (hdr_q.size() > 0);
            bus.num_words_i     = (hdr_q.size() > 0) ? hdr_q[0] : '0;
        end
    end

    // ZNZ driver
    initial begin
        logic f;
        bus.znz_vld_i = 1'b0;
        bus.znz_i     = '0;
        forever begin
            @(negedge clk);
            f = bus.znz_vld_i && bus.znz_rdy_o;
            @(posedge clk);
            #1;
            if (f && znz_q.size() > 0) begin
                void'(znz_q.pop_front());
                znz_xfers++;
            end
            bus.znz_vld_i = (znz_q.size() > 0);
            bus.znz_i     = (znz_q.size() > 0) ? znz_q[0] : '0;
        end
    end

    // BPC driver
    initial begin
        logic f;
        bus.bpc_vld_i = 1'b0;
        bus.bpc_i     = '0;
        forever begin
            @(negedge clk);
            f = bus.bpc_vld_i && bus.bpc_rdy_o;
            @(posedge clk);
            #1;
            if (f && bpc_q.size() > 0) begin
                void'(bpc_q.pop_front());
                bpc_xfers++;
            end
            bus.bpc_vld_i = (bpc_q.size() > 0);
            bus.bpc_i     = (bpc_q.size() > 0) ? bpc_q[0] : '0;
        end
    end

    // Monitor: accepted beats against the scoreboard, stalled beats against their snapshot
    initial begin
        beat_t snap;
        beat_t got;
        beat_t e;
        logic  holding;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            got.data = bus.data_o;
            got.lv   = bus.lane_vld_o;
            got.last = bus.last_o;
            if (rst) begin
                holding = 1'b0;
            end else begin
                if (holding) check("hold_stable", 64'(got), 64'(snap));
                if (bus.vld_o && bus.rdy_i) begin
                    holding = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("beat_unexpected", 64'(got), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", 64'(got.data), 64'(e.data));
                        check("beat_lane_vld", 64'(got.lv), 64'(e.lv));
                        check("beat_last", 64'(got.last), 64'(e.last));
                    end
                end else if (bus.vld_o) begin
                    holding = 1'b1;
                    snap    = got;
                end else begin
                    holding = 1'b0;
                end
            end
        end
    end

    task automatic wait_done(input string name);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic load_test1();
        hdr_q.push_back(LW'(7));
        znz_q.push_back(8'hA5);
        bpc_q.push_back(8'd11); bpc_q.push_back(8'd22);
        bpc_q.push_back(8'd33); bpc_q.push_back(8'd44);
        push_beat(pack4(8'd11, 8'd0, 8'd22, 8'd0), 4'hF, 1'b0);
        push_beat(pack4(8'd0, 8'd33, 8'd0, 8'd44), 4'hF, 1'b1);
    endtask

    initial begin
        #300000;
        checks++;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int z0, b0;
        logic seen;
        bus.rdy_i = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_vld", 64'(bus.vld_o), 64'd0);
        check("rst_data", 64'(bus.data_o), 64'd0);
        check("rst_lane_vld", 64'(bus.lane_vld_o), 64'd0);
        check("rst_last", 64'(bus.last_o), 64'd0);
        check("rst_rdys", 64'({bus.num_words_rdy_o, bus.znz_rdy_o, bus.bpc_rdy_o}), 64'd0);
        rst = 1'b0;
        #1;
        check("idle_hdr_rdy", 64'(bus.num_words_rdy_o), 64'd1);
        check("idle_other_rdy", 64'({bus.znz_rdy_o, bus.bpc_rdy_o}), 64'd0);
        @(posedge clk);
        #2;

        // Test 1: mixed mask 0xA5
        z0 = znz_xfers; b0 = bpc_xfers;
        load_test1();
        wait_done("t1");
        check("t1_znz_xfers", 64'(znz_xfers - z0), 64'd1);
        check("t1_bpc_xfers", 64'(bpc_xfers - b0), 64'd4);
`ifdef EBPC_ZNZ_STATS_EN
        check("t6_nz_cnt_blk1", 64'(nz_cnt), 64'd4);
`endif

        // Test 2: all-zero mask, partial final beat
        z0 = znz_xfers; b0 = bpc_xfers;
        hdr_q.push_back(LW'(5));
        znz_q.push_back(8'h00);
        push_beat('0, 4'hF, 1'b0);
        push_beat('0, 4'h3, 1'b1);
        wait_done("t2");
        check("t2_znz_xfers", 64'(znz_xfers - z0), 64'd1);
        check("t2_bpc_xfers", 64'(bpc_xfers - b0), 64'd0);
`ifdef EBPC_ZNZ_STATS_EN
        check("t6_nz_cnt_blk2", 64'(nz_cnt), 64'd0);
`endif

        // Test 3: block spanning two mask words, starts on a fresh word
        z0 = znz_xfers; b0 = bpc_xfers;
        hdr_q.push_back(LW'(9));
        znz_q.push_back(8'hFF); znz_q.push_back(8'h03);
        for (int i = 1; i <= 10; i++) bpc_q.push_back(DW'(i));
        push_beat(pack4(8'd1, 8'd2, 8'd3, 8'd4), 4'hF, 1'b0);
        push_beat(pack4(8'd5, 8'd6, 8'd7, 8'd8), 4'hF, 1'b0);
        push_beat(pack4(8'd9, 8'd10, 8'd0, 8'd0), 4'h3, 1'b1);
        wait_done("t3");
        check("t3_znz_xfers", 64'(znz_xfers - z0), 64'd2);
        check("t3_bpc_xfers", 64'(bpc_xfers - b0), 64'd10);

        // Test 4: test 1 with the first beat back-pressured
        bus.rdy_i = 1'b0;
        load_test1();
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (bus.vld_o) begin
                seen = 1'b1;
                break;
            end
        end
        check("t4_vld_seen", 64'(seen), 64'd1);
        z0 = znz_xfers; b0 = bpc_xfers;
        repeat (5) @(posedge clk);
        #2;
        check("t4_stall_znz", 64'(znz_xfers - z0), 64'd0);
        check("t4_stall_bpc", 64'(bpc_xfers - b0), 64'd0);
        check("t4_stall_vld", 64'(bus.vld_o), 64'd1);
        bus.rdy_i = 1'b1;
        wait_done("t4");

        // Test 5: reset after two elements of test 3
        b0 = bpc_xfers;
        hdr_q.push_back(LW'(9));
        znz_q.push_back(8'hFF); znz_q.push_back(8'h03);
        for (int i = 1; i <= 10; i++) bpc_q.push_back(DW'(i));
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (bpc_xfers - b0 >= 2) break;
        end
        check("t5_two_elems", 64'(bpc_xfers - b0), 64'd2);
        rst = 1'b1;
        #1;
        check("t5_rst_rdys", 64'({bus.num_words_rdy_o, bus.znz_rdy_o, bus.bpc_rdy_o}), 64'd0);
        @(posedge clk);
        #2;
        hdr_q.delete(); znz_q.delete(); bpc_q.delete(); exp_q.delete();
        check("t5_rst_vld", 64'(bus.vld_o), 64'd0);
        check("t5_rst_lane_vld", 64'(bus.lane_vld_o), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t5_post_vld", 64'(bus.vld_o), 64'd0);
        check("t5_post_hdr_rdy", 64'(bus.num_words_rdy_o), 64'd1);
        @(posedge clk);
        #2;
        z0 = znz_xfers; b0 = bpc_xfers;
        hdr_q.push_back(LW'(0));
        znz_q.push_back(8'h01);
        bpc_q.push_back(8'h7F);
        push_beat(pack4(8'h7F, 8'd0, 8'd0, 8'd0), 4'h1, 1'b1);
        wait_done("t5");
        check("t5_znz_xfers", 64'(znz_xfers - z0), 64'd1);
        check("t5_bpc_xfers", 64'(bpc_xfers - b0), 64'd1);
        check("t5_idle_rdy", 64'(bus.num_words_rdy_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
